// File: rtl/peripheral_bus_bridge_if.sv
// peripheral_bus_bridge_if: host request/response port plus register/memory strobe port
interface peripheral_bus_bridge_if;
  logic host_req, host_ready, host_write, host_resp_valid, host_error;
  logic [31:0] host_address, host_wdata, host_rdata;
  logic reg_read, reg_write, reg_read_valid;
  logic [1:0] reg_address;
  logic [31:0] reg_data_in, reg_data_out;
  logic mem_read, mem_write, mem_read_valid;
  logic [7:0] mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  modport slave (
    input host_req, host_write, host_address, host_wdata,
    input reg_read_valid, reg_data_out, mem_read_valid, mem_data_out,
    output host_ready, host_resp_valid, host_rdata, host_error,
    output reg_read, reg_write, reg_address, reg_data_in,
    output mem_read, mem_write, mem_address, mem_data_in
  );
  modport master (
    output host_req, host_write, host_address, host_wdata,
    output reg_read_valid, reg_data_out, mem_read_valid, mem_data_out,
    input host_ready, host_resp_valid, host_rdata, host_error,
    input reg_read, reg_write, reg_address, reg_data_in,
    input mem_read, mem_write, mem_address, mem_data_in
  );
endinterface

// File: rtl/peripheral_bus_bridge.sv
// peripheral_bus_bridge: decodes single-word host requests into register/memory strobes,
// one response per accepted request; unmapped, misaligned or unanswered reads respond with error
module peripheral_bus_bridge #(
  parameter logic [31:0] REG_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_BASE = 32'h0000_0400,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  peripheral_bus_bridge_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic wr_q, mem_q, err_q, err_n, reg_hit, mem_hit, bad, issue, vld, done;
  logic [7:0] addr_q;
  logic [31:0] wdata_q, rdata_q, rdata_n, dout;
  logic [CW-1:0] cnt_q, cnt_n;
  assign reg_hit = bus.host_address[31:4] == REG_BASE[31:4];
  assign mem_hit = bus.host_address[31:10] == MEM_BASE[31:10];
  assign bad = !(reg_hit || mem_hit) || bus.host_address[1:0] != 2'b00;
  // only the window this request targets may complete it
  assign vld = mem_q ? bus.mem_read_valid : bus.reg_read_valid;
  assign dout = mem_q ? bus.mem_data_out : bus.reg_data_out;
  assign done = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    err_n = err_q;
    rdata_n = rdata_q;
    cnt_n = cnt_q;
    case (state)
      IDLE: begin
        state_n = bus.host_req ? (bad ? RESP : ISSUE) : IDLE;
        err_n = (bus.host_req && bad) ? 1'b1 : err_q;
        rdata_n = (bus.host_req && bad) ? '0 : rdata_q;
      end
      ISSUE: begin
        state_n = (wr_q || vld) ? RESP : WAIT;
        err_n = (wr_q || vld) ? 1'b0 : err_q;
        rdata_n = wr_q ? '0 : vld ? dout : rdata_q;
        cnt_n = '0;
      end
      WAIT: begin
        state_n = (vld || done) ? RESP : WAIT;
        err_n = vld ? 1'b0 : done ? 1'b1 : err_q;
        rdata_n = vld ? dout : done ? '0 : rdata_q;
        cnt_n = cnt_q + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_q <= 1'b0;
      mem_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      err_q <= err_n;
      rdata_q <= rdata_n;
      cnt_q <= cnt_n;
      if (state == IDLE && bus.host_req) begin
        wr_q <= bus.host_write;
        mem_q <= !reg_hit;
        addr_q <= bus.host_address[9:2];
        wdata_q <= bus.host_wdata;
      end
    end
  end
  assign issue = state == ISSUE;
  assign bus.host_ready = state == IDLE;
  assign bus.host_resp_valid = state == RESP;
  assign bus.host_rdata = rdata_q;
  assign bus.host_error = err_q;
  assign bus.reg_read = issue && !mem_q && !wr_q;
  assign bus.reg_write = issue && !mem_q && wr_q;
  assign bus.mem_read = issue && mem_q && !wr_q;
  assign bus.mem_write = issue && mem_q && wr_q;
  assign bus.reg_address = (issue && !mem_q) ? addr_q[1:0] : '0;
  assign bus.mem_address = (issue && mem_q) ? addr_q : '0;
  assign bus.reg_data_in = bus.reg_write ? wdata_q : '0;
  assign bus.mem_data_in = bus.mem_write ? wdata_q : '0;
endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// tb_peripheral_bus_bridge: directed vector table plus multi-cycle sequences
// against a small register/memory peripheral model answering one cycle after each read strobe
module tb_peripheral_bus_bridge;
  localparam int RR = 1, RW = 4, MR = 16, MW = 64;
  typedef struct {
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    int lat;
    logic er;
    logic [31:0] rd;
    int str;
    logic [7:0] sa;
    logic [31:0] sd;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stub = 1'b0;
  int checks = 0, errors = 0;
  peripheral_bus_bridge_if bus();
  peripheral_bus_bridge dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] regs [4];
  logic [31:0] mem [256];
  logic reg_rv, mem_rv;
  logic [31:0] reg_rd, mem_rd;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      reg_rv <= 1'b0;
      mem_rv <= 1'b0;
      reg_rd <= '0;
      mem_rd <= '0;
    end else begin
      if (bus.reg_write) regs[bus.reg_address] <= bus.reg_data_in;
      if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_in;
      reg_rv <= bus.reg_read && !stub;
      mem_rv <= bus.mem_read;
      reg_rd <= regs[bus.reg_address];
      mem_rd <= mem[bus.mem_address];
    end
  end
  // stub silences register reads and asserts the wrong window's valid continuously
  assign bus.reg_read_valid = reg_rv;
  assign bus.reg_data_out = reg_rd;
  assign bus.mem_read_valid = mem_rv || stub;
  assign bus.mem_data_out = mem_rd;
  int t_lat, t_str;
  logic t_er, t_rdy;
  logic [31:0] t_rd, t_sd;
  logic [7:0] t_sa;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    int k;
    t_lat = -1;
    t_str = 0;
    t_sa = '0;
    t_sd = '0;
    t_rd = 'x;
    t_er = 1'bx;
    t_rdy = 1'bx;
    @(negedge clk);
    k = 0;
    while (!bus.host_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    bus.host_req = 1'b1;
    bus.host_write = w;
    bus.host_address = a;
    bus.host_wdata = d;
    for (int i = 1; i <= 40 && t_lat < 0; i++) begin
      @(negedge clk);
      bus.host_req = 1'b0;
      t_str += RR * int'(bus.reg_read) + RW * int'(bus.reg_write) + MR * int'(bus.mem_read) + MW * int'(bus.mem_write);
      if (bus.reg_read || bus.reg_write) begin
        t_sa = {6'b0, bus.reg_address};
        t_sd = bus.reg_data_in;
      end
      if (bus.mem_read || bus.mem_write) begin
        t_sa = bus.mem_address;
        t_sd = bus.mem_data_in;
      end
      if (bus.host_resp_valid) begin
        t_lat = i;
        t_rd = bus.host_rdata;
        t_er = bus.host_error;
        t_rdy = bus.host_ready;
      end
    end
  endtask
  vec_t v [16];
  int nw, nr, nrdy;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.host_req = 1'b0;
    bus.host_write = 1'b0;
    bus.host_address = '0;
    bus.host_wdata = '0;
    v[0]  = '{1'b1, 32'd4,    32'd3,      2, 1'b0, 32'd0,      RW, 8'd1,   32'd3};
    v[1]  = '{1'b1, 32'd0,    32'd67,     2, 1'b0, 32'd0,      RW, 8'd0,   32'd67};
    v[2]  = '{1'b0, 32'd0,    32'd0,      3, 1'b0, 32'd67,     RR, 8'd0,   32'd0};
    v[3]  = '{1'b0, 32'd8,    32'd0,      3, 1'b0, 32'd0,      RR, 8'd2,   32'd0};
    v[4]  = '{1'b0, 32'd4,    32'd0,      3, 1'b0, 32'd3,      RR, 8'd1,   32'd0};
    v[5]  = '{1'b0, 32'd512,  32'd0,      1, 1'b1, 32'd0,      0,  8'd0,   32'd0};
    v[6]  = '{1'b1, 32'd2048, 32'd5,      1, 1'b1, 32'd0,      0,  8'd0,   32'd0};
    v[7]  = '{1'b0, 32'd6,    32'd0,      1, 1'b1, 32'd0,      0,  8'd0,   32'd0};
    v[8]  = '{1'b1, 32'd12,   32'h1234,   2, 1'b0, 32'd0,      RW, 8'd3,   32'h1234};
    v[9]  = '{1'b0, 32'd12,   32'd0,      3, 1'b0, 32'h1234,   RR, 8'd3,   32'd0};
    v[10] = '{1'b0, 32'd16,   32'd0,      1, 1'b1, 32'd0,      0,  8'd0,   32'd0};
    v[11] = '{1'b1, 32'd2044, 32'hcafe,   2, 1'b0, 32'd0,      MW, 8'd255, 32'hcafe};
    v[12] = '{1'b0, 32'd2044, 32'd0,      3, 1'b0, 32'hcafe,   MR, 8'd255, 32'd0};
    v[13] = '{1'b0, 32'd1026, 32'd0,      1, 1'b1, 32'd0,      0,  8'd0,   32'd0};
    v[14] = '{1'b0, 32'd1020, 32'd0,      1, 1'b1, 32'd0,      0,  8'd0,   32'd0};
    v[15] = '{1'b0, 32'd1024, 32'd0,      3, 1'b0, 32'd0,      MR, 8'd0,   32'd0};
    #12;
    chk("rst_ready", {31'b0, bus.host_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.host_resp_valid}, 32'd0);
    chk("rst_rdata", bus.host_rdata, 32'd0);
    chk("rst_error", {31'b0, bus.host_error}, 32'd0);
    chk("rst_strobes", {28'b0, bus.reg_read, bus.reg_write, bus.mem_read, bus.mem_write}, 32'd0);
    chk("rst_addr", {22'b0, bus.reg_address, bus.mem_address}, 32'd0);
    chk("rst_data_in", bus.reg_data_in | bus.mem_data_in, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      txn(v[i].w, v[i].a, v[i].d);
      chk($sformatf("v%0d_latency", i), t_lat, v[i].lat);
      chk($sformatf("v%0d_error", i), {31'b0, t_er}, {31'b0, v[i].er});
      chk($sformatf("v%0d_rdata", i), t_rd, v[i].rd);
      chk($sformatf("v%0d_strobes", i), t_str, v[i].str);
      chk($sformatf("v%0d_ready_in_resp", i), {31'b0, t_rdy}, 32'd0);
      if (v[i].str != 0) begin
        chk($sformatf("v%0d_strobe_addr", i), {24'b0, t_sa}, {24'b0, v[i].sa});
        chk($sformatf("v%0d_strobe_data", i), t_sd, v[i].sd);
      end
    end
    // request held high: one write accepted every third cycle
    @(negedge clk);
    bus.host_req = 1'b1;
    bus.host_write = 1'b1;
    bus.host_address = 32'd8;
    bus.host_wdata = 32'd5;
    nw = 0;
    nr = 0;
    nrdy = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      nw += int'(bus.reg_write);
      nr += int'(bus.host_resp_valid);
      nrdy += int'(bus.host_ready);
      if (k == 9) bus.host_req = 1'b0;
    end
    chk("b2b_strobes", nw, 3);
    chk("b2b_responses", nr, 3);
    chk("b2b_ready_cycles", nrdy, 3);
    for (int i = 1024; i <= 2044; i += 4) txn(1'b1, i, i);
    for (int i = 1024; i <= 2044; i += 4) begin
      txn(1'b0, i, 32'd0);
      chk($sformatf("sweep_rdata_%0d", i), t_rd, i);
      chk($sformatf("sweep_addr_%0d", i), {24'b0, t_sa}, (i - 1024) / 4);
      chk($sformatf("sweep_strobes_%0d", i), t_str, MR);
    end
    stub = 1'b1;
    txn(1'b0, 32'd0, 32'd0);
    chk("timeout_latency", t_lat, 18);
    chk("timeout_error", {31'b0, t_er}, 32'd1);
    chk("timeout_rdata", t_rd, 32'd0);
    chk("timeout_strobes", t_str, RR);
    stub = 1'b0;
    txn(1'b0, 32'd0, 32'd0);
    chk("after_timeout_latency", t_lat, 3);
    chk("after_timeout_rdata", t_rd, 32'd67);
    chk("after_timeout_error", {31'b0, t_er}, 32'd0);
    stub = 1'b1;
    @(negedge clk);
    bus.host_req = 1'b1;
    bus.host_write = 1'b0;
    bus.host_address = 32'd0;
    @(negedge clk);
    bus.host_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_resp_valid", {31'b0, bus.host_resp_valid}, 32'd0);
    chk("midrst_rdata", bus.host_rdata, 32'd0);
    chk("midrst_error", {31'b0, bus.host_error}, 32'd0);
    chk("midrst_ready", {31'b0, bus.host_ready}, 32'd1);
    chk("midrst_strobes", {28'b0, bus.reg_read, bus.reg_write, bus.mem_read, bus.mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stub = 1'b0;
    nr = 0;
    nrdy = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      nr += int'(bus.host_resp_valid);
      nrdy += int'(bus.host_ready);
    end
    chk("midrst_no_response", nr, 0);
    chk("midrst_ready_cycles", nrdy, 30);
    txn(1'b1, 32'd8, 32'h77);
    chk("post_rst_write_latency", t_lat, 2);
    txn(1'b0, 32'd8, 32'd0);
    chk("post_rst_read_latency", t_lat, 3);
    chk("post_rst_read_rdata", t_rd, 32'h77);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
